cla_pipe: RTL and testbench
===========================

CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand/sum width in bits.
REQ-002 Parameter: STAGES, 4, number of pipeline slices; WIDTH SHALL be a multiple of STAGES and STAGES >= 1.
REQ-003 Port: clk  input  1  single clock, all state updates on posedge clk.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  input beat present.
REQ-006 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: ci  input  1  carry-in; used only when sub=0.
REQ-010 Port: sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result beat present.
REQ-012 Port: out_ready  input  1  downstream accepts result this cycle.
REQ-013 Port: s  output  WIDTH  registered sum/difference.
REQ-014 Port: co  output  1  registered carry-out of MSB.
REQ-015 Port: ovf  output  1  registered two's-complement signed overflow.

Function
REQ-016 Beat accepted on posedge clk when in_valid && in_ready; transfer out on posedge clk when out_valid && out_ready.
REQ-017 sub=0: {co,s} = a + b + ci; sub=1: {co,s} = a + ~b + 1 (ci ignored), so co=1 means no borrow.
REQ-018 ovf = (A_msb == B'_msb) && (s_msb != A_msb), with B' = b (add) or ~b (sub).
REQ-019 Operands split into STAGES slices of WIDTH/STAGES bits; slice i computed with carry-lookahead in stage i+1, carry between slices passed through a pipeline register.
REQ-020 Stage 1 captures slice 0 result, its carry, mode and the unprocessed upper operand bits; each later stage computes one further slice and forwards the already-computed lower bits.
REQ-021 Latency: result of a beat accepted at edge k SHALL be on s/co/ovf with out_valid=1 after edge k+STAGES-1 (STAGES edges, accept edge counted).
REQ-022 Throughput: one beat per cycle when out_ready=1 continuously.
REQ-023 Each stage has a valid bit; the whole pipeline advances only when enable = !(out_valid && !out_ready).
REQ-024 in_ready = enable (combinational); in_ready SHALL be 1 whenever out_valid=0 or out_ready=1.
REQ-025 While stalled (out_valid=1, out_ready=0), s/co/ovf/out_valid and all stage registers SHALL hold unchanged.
REQ-026 Bubbles (in_valid=0 on an enabled edge) propagate as valid=0; stage data in a bubble is don't-care but outputs SHALL update only when a valid beat reaches the last stage.
REQ-027 Beat order preserved; no beat dropped or duplicated under any out_ready pattern.
REQ-028 Simultaneous output transfer and input accept on the same edge SHALL both take effect.
REQ-029 Input a/b/ci/sub sampled only on the accept edge; changes at other times have no effect.

Reset
REQ-030 reset_n=0 SHALL immediately (asynchronously) clear all stage valid bits, out_valid=0, s=0, co=0, ovf=0.
REQ-031 During reset and on the first cycle after deassertion in_ready=1.
REQ-032 Reset mid-operation discards all in-flight beats; none emerge after reset release.
REQ-033 Reset deassertion is synchronised externally; no internal reset synchroniser.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-034 a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0, out_ready=1 -> after 4 edges out_valid=1, s=0x00000000, co=1, ovf=0.
REQ-035 a=0x7FFFFFFF, b=0x00000001, ci=0, sub=0 -> s=0x80000000, co=0, ovf=1; a=0x0000FFFF, b=0, ci=1 -> s=0x00010000, co=0.
REQ-036 sub=1, a=5, b=7 -> s=0xFFFFFFFE, co=0, ovf=0; next beat a=7, b=5 -> s=0x00000002, co=1; a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1.
REQ-037 8 back-to-back beats (a=i, b=i*3), out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 && out_ready=0; 8 results 4*i in order, none lost or duplicated.
REQ-038 3 beats in flight, reset_n pulsed low mid-cycle -> out_valid=0 and s=0 immediately; no result appears for those beats after release; next beat has normal 4-cycle latency.
REQ-039 WIDTH=8, STAGES=1: a=0x80, b=0x80, sub=0 -> s=0x00, co=1, ovf=1, out_valid one edge after accept.

Source files
------------

// File: rtl/cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cla_pipe : pipelined carry-lookahead adder/subtractor, one slice per stage  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Stage inputs. x carries {computed sum bits, remaining A bits} rotated so the
  // next A slice always sits in [SW-1:0]; y carries the remaining B' bits likewise.
  logic [WIDTH-1:0] x_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic             enable;

  assign enable   = !(out_valid && !out_ready);
  assign in_ready = enable;

  assign x_in[0] = a;
  assign y_in[0] = sub ? ~b : b;
  assign c_in[0] = sub | ci;
  assign v_in[0] = in_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [SW-1:0] p, g, sum;
    logic [SW:0]   c;
    logic          acc, prod;

    // Flattened lookahead: c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]c[0]
    always_comb begin
      p    = x_in[i][SW-1:0] ^ y_in[i][SW-1:0];
      g    = x_in[i][SW-1:0] & y_in[i][SW-1:0];
      c    = '0;
      acc  = 1'b0;
      prod = 1'b0;
      c[0] = c_in[i];
      for (int k = 0; k < SW; k++) begin
        acc  = g[k];
        prod = p[k];
        for (int j = k - 1; j >= 0; j--) begin
          acc  = acc | (prod & g[j]);
          prod = prod & p[j];
        end
        c[k+1] = acc | (prod & c_in[i]);
      end
      sum = p ^ c[SW-1:0];
    end

    if (i == STAGES - 1) begin : g_last
      logic [WIDTH-1:0] s_nxt;

      if (STAGES == 1) begin : g_single
        assign s_nxt = sum;
      end else begin : g_multi
        assign s_nxt = {sum, x_in[i][WIDTH-1:SW]};
      end

      // Result registers only move when a real beat arrives, so bubbles leave them intact.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          co        <= 1'b0;
          ovf       <= 1'b0;
        end else if (enable) begin
          out_valid <= v_in[i];
          if (v_in[i]) begin
            s   <= s_nxt;
            co  <= c[SW];
            ovf <= c[SW] ^ c[SW-1];
          end
        end
      end
    end else begin : g_mid
      logic [WIDTH-1:0] x_r, y_r;
      logic             c_r, v_r;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_r <= '0;
          y_r <= '0;
          c_r <= 1'b0;
          v_r <= 1'b0;
        end else if (enable) begin
          x_r <= {sum, x_in[i][WIDTH-1:SW]};
          y_r <= {y_in[i][SW-1:0], y_in[i][WIDTH-1:SW]};
          c_r <= c[SW];
          v_r <= v_in[i];
        end
      end

      assign x_in[i+1] = x_r;
      assign y_in[i+1] = y_r;
      assign c_in[i+1] = c_r;
      assign v_in[i+1] = v_r;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cla_pipe : scoreboard bench for cla_pipe (32/4 and 8/1 configurations)   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cla_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        ci, sub, co, ovf;

  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  a8, b8, s8;
  logic        co8, ovf8;

  int          tests;
  int          fails;
  logic [33:0] exp_q [$];

  cla_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  cla_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(1'b0), .sub(1'b0), .out_valid(out_valid8), .out_ready(1'b1),
    .s(s8), .co(co8), .ovf(ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drives one beat from a negedge, holds it until accepted, then scrambles the inputs.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                       input logic tsub, input logic [31:0] es, input logic eco,
                       input logic eovf);
    int wait_cnt;
    @(negedge clk);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for a=%h", ta);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({es, eco, eovf});
      #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb; ci = ~tci; sub = ~tsub;
    end
  endtask

  // Monitor: samples late in the low phase, just before the edge that would transfer.
  initial begin
    logic        stalled_prev;
    logic [33:0] prev_out;
    logic [33:0] exp_v;
    stalled_prev = 1'b0;
    prev_out     = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        stalled_prev = 1'b0;
      end else begin
        check("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
        if (stalled_prev) begin
          check("stall_hold", {29'd0, out_valid, s, co, ovf}, {29'd0, 1'b1, prev_out});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got s=%h co=%b ovf=%b, none expected", s, co, ovf);
          end else begin
            exp_v = exp_q.pop_front();
            check("result", {30'd0, s, co, ovf}, {30'd0, exp_v});
          end
        end
        stalled_prev = out_valid && !out_ready;
        prev_out     = {s, co, ovf};
      end
    end
  end

  initial begin
    int n;
    tests = 0; fails = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;

    #12;
    check("reset_outputs", {29'd0, out_valid, s, co, ovf}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Wrap-around add and first-beat latency
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'd4);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    issue(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    issue(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    issue(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    repeat (8) @(negedge clk);

    // Back-to-back beats with a 3-cycle downstream stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          issue(32'(i), 32'(i * 3), 1'b0, 1'b0, 32'(i * 4), 1'b0, 1'b0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    issue(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0);
    issue(32'h0000_0044, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0099, 1'b0, 1'b0);
    issue(32'h0000_0066, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_00DD, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_clear", {29'd0, out_valid, s, co, ovf}, 64'd0);
    check("reset_in_ready_mid", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_ghost_beats", {63'd0, out_valid}, 64'd0);

    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_after_reset", 64'(n), 64'd4);
    repeat (4) @(negedge clk);

    // Single-stage 8-bit instance
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    check("w8_ready", {63'd0, in_ready8}, 64'd1);
    check("w8_idle", {63'd0, out_valid8}, 64'd0);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
    check("w8_result", {53'd0, out_valid8, s8, co8, ovf8}, {53'd0, 1'b1, 8'h00, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    check("w8_bubble", {53'd0, out_valid8, s8, co8, ovf8}, {53'd0, 1'b0, 8'h00, 1'b1, 1'b1});

    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
